// File: rtl/alu_rs_dispatch_if.sv
// alu_rs_dispatch_if: dispatch, CDB, issue and occupancy signals of the ALU reservation station
interface alu_rs_dispatch_if #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [15:0]      disp_pc;
  logic [3:0]       disp_opcode;
  logic [15:0]      disp_op1;
  logic             disp_op1_v;
  logic [TAG_W-1:0] disp_op1_tag;
  logic [15:0]      disp_op2;
  logic             disp_op2_v;
  logic [TAG_W-1:0] disp_op2_tag;
  logic [TAG_W-1:0] disp_rrf_dest;
  logic [1:0]       disp_cz;
  logic             disp_cmp;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [15:0]      cdb_data;
  logic             iss_valid;
  logic [15:0]      iss_pc;
  logic [3:0]       iss_opcode;
  logic [15:0]      iss_opr1;
  logic [15:0]      iss_opr2;
  logic [TAG_W-1:0] iss_rrf_dest;
  logic [1:0]       iss_cz;
  logic             iss_cmp;
  logic [CW-1:0]    count;
  modport slave (
    input  flush, disp_valid, disp_pc, disp_opcode, disp_op1, disp_op1_v, disp_op1_tag,
           disp_op2, disp_op2_v, disp_op2_tag, disp_rrf_dest, disp_cz, disp_cmp,
           cdb_valid, cdb_tag, cdb_data,
    output disp_ready, iss_valid, iss_pc, iss_opcode, iss_opr1, iss_opr2, iss_rrf_dest,
           iss_cz, iss_cmp, count
  );
  modport master (
    output flush, disp_valid, disp_pc, disp_opcode, disp_op1, disp_op1_v, disp_op1_tag,
           disp_op2, disp_op2_v, disp_op2_tag, disp_rrf_dest, disp_cz, disp_cmp,
           cdb_valid, cdb_tag, cdb_data,
    input  disp_ready, iss_valid, iss_pc, iss_opcode, iss_opr1, iss_opr2, iss_rrf_dest,
           iss_cz, iss_cmp, count
  );
endinterface

// File: rtl/alu_rs_dispatch.sv
// alu_rs_dispatch: reservation station that waits for operands on the CDB and issues one ready op per cycle
module alu_rs_dispatch #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input logic             clk,
  input logic             rst,
  alu_rs_dispatch_if.slave rs
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic             v;
    logic [15:0]      pc;
    logic [3:0]       op;
    logic [15:0]      o1;
    logic             o1v;
    logic [TAG_W-1:0] t1;
    logic [15:0]      o2;
    logic             o2v;
    logic [TAG_W-1:0] t2;
    logic [TAG_W-1:0] dest;
    logic [1:0]       cz;
    logic             cmp;
  } ent_t;
  typedef struct packed {
    logic [15:0]      pc;
    logic [3:0]       op;
    logic [15:0]      o1;
    logic [15:0]      o2;
    logic [TAG_W-1:0] dest;
    logic [1:0]       cz;
    logic             cmp;
  } iss_t;
  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          new_ent;
  iss_t          iss_q, iss_d;
  logic          iss_v_q, iss_v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] free_idx, sel_idx;
  logic          has_sel, disp_fire, byp1, byp2;
  assign rs.disp_ready = cnt_q != CW'(DEPTH);
  assign disp_fire = rs.disp_valid && rs.disp_ready && !rs.flush;
  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    has_sel  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].v) free_idx = IW'(i);
      if (ent_q[i].v && ent_q[i].o1v && ent_q[i].o2v) begin
        sel_idx = IW'(i);
        has_sel = 1'b1;
      end
    end
  end
  // Same-cycle broadcast is captured at dispatch so it cannot be missed.
  always_comb begin
    byp1         = !rs.disp_op1_v && rs.cdb_valid && rs.cdb_tag == rs.disp_op1_tag;
    byp2         = !rs.disp_op2_v && rs.cdb_valid && rs.cdb_tag == rs.disp_op2_tag;
    new_ent.v    = 1'b1;
    new_ent.pc   = rs.disp_pc;
    new_ent.op   = rs.disp_opcode;
    new_ent.o1   = byp1 ? rs.cdb_data : rs.disp_op1;
    new_ent.o1v  = rs.disp_op1_v || byp1;
    new_ent.t1   = rs.disp_op1_tag;
    new_ent.o2   = byp2 ? rs.cdb_data : rs.disp_op2;
    new_ent.o2v  = rs.disp_op2_v || byp2;
    new_ent.t2   = rs.disp_op2_tag;
    new_ent.dest = rs.disp_rrf_dest;
    new_ent.cz   = rs.disp_cz;
    new_ent.cmp  = rs.disp_cmp;
  end
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].v && !ent_q[i].o1v && rs.cdb_valid && ent_q[i].t1 == rs.cdb_tag) begin
        ent_d[i].o1  = rs.cdb_data;
        ent_d[i].o1v = 1'b1;
      end
      if (ent_q[i].v && !ent_q[i].o2v && rs.cdb_valid && ent_q[i].t2 == rs.cdb_tag) begin
        ent_d[i].o2  = rs.cdb_data;
        ent_d[i].o2v = 1'b1;
      end
    end
    if (has_sel) ent_d[sel_idx].v = 1'b0;
    if (disp_fire) ent_d[free_idx] = new_ent;
    if (rs.flush) for (int i = 0; i < DEPTH; i++) ent_d[i].v = 1'b0;
  end
  always_comb begin
    iss_v_d = has_sel && !rs.flush;
    iss_d   = iss_v_d ? {ent_q[sel_idx].pc, ent_q[sel_idx].op, ent_q[sel_idx].o1, ent_q[sel_idx].o2,
                         ent_q[sel_idx].dest, ent_q[sel_idx].cz, ent_q[sel_idx].cmp} : iss_q;
    cnt_d   = rs.flush ? '0 : cnt_q + CW'(disp_fire) - CW'(has_sel);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      iss_q   <= '0;
      iss_v_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      iss_q   <= iss_d;
      iss_v_q <= iss_v_d;
      cnt_q   <= cnt_d;
    end
  end
  assign rs.iss_valid    = iss_v_q;
  assign rs.iss_pc       = iss_q.pc;
  assign rs.iss_opcode   = iss_q.op;
  assign rs.iss_opr1     = iss_q.o1;
  assign rs.iss_opr2     = iss_q.o2;
  assign rs.iss_rrf_dest = iss_q.dest;
  assign rs.iss_cz       = iss_q.cz;
  assign rs.iss_cmp      = iss_q.cmp;
  assign rs.count        = cnt_q;
endmodule

// File: tb/tb_alu_rs_dispatch.sv
// tb_alu_rs_dispatch: scoreboard bench for the ALU reservation station
module tb_alu_rs_dispatch;
  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  op;
    logic [15:0] o1;
    logic [15:0] o2;
    logic [4:0]  dest;
    logic [1:0]  cz;
    logic        cmp;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t mon_g;
  alu_rs_dispatch_if #(.TAG_W(5), .DEPTH(8)) bus ();
  alu_rs_dispatch #(.DEPTH(8), .TAG_W(5)) dut (.clk(clk), .rst(rst), .rs(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.iss_valid === 1'b1) begin
      vectors++;
      mon_g = {bus.iss_pc, bus.iss_opcode, bus.iss_opr1, bus.iss_opr2, bus.iss_rrf_dest, bus.iss_cz, bus.iss_cmp};
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue got pc=%h opr1=%h opr2=%h", bus.iss_pc, bus.iss_opr1, bus.iss_opr2);
      end else begin
        mon_e = sb.pop_front();
        if (mon_g !== mon_e) begin
          miscompares++;
          $display("FAIL issue_fields got %h expected %h", mon_g, mon_e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_disp(input logic [15:0] pc, input logic [3:0] op,
                            input logic [15:0] o1, input logic o1v, input logic [4:0] t1,
                            input logic [15:0] o2, input logic o2v, input logic [4:0] t2,
                            input logic [4:0] dest, input logic [15:0] e1, input logic [15:0] e2,
                            input bit push);
    bus.disp_valid = 1'b1;
    bus.disp_pc = pc;
    bus.disp_opcode = op;
    bus.disp_op1 = o1;
    bus.disp_op1_v = o1v;
    bus.disp_op1_tag = t1;
    bus.disp_op2 = o2;
    bus.disp_op2_v = o2v;
    bus.disp_op2_tag = t2;
    bus.disp_rrf_dest = dest;
    bus.disp_cz = pc[1:0];
    bus.disp_cmp = pc[2];
    if (push) sb.push_back({pc, op, e1, e2, dest, pc[1:0], pc[2]});
    step();
    bus.disp_valid = 1'b0;
  endtask
  task automatic broadcast(input logic [4:0] tag, input logic [15:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = tag;
    bus.cdb_data = data;
    step();
    bus.cdb_valid = 1'b0;
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset();
    bus.flush = 0; bus.disp_valid = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    bus.disp_pc = 0; bus.disp_opcode = 0; bus.disp_op1 = 0; bus.disp_op1_v = 0; bus.disp_op1_tag = 0;
    bus.disp_op2 = 0; bus.disp_op2_v = 0; bus.disp_op2_tag = 0; bus.disp_rrf_dest = 0;
    bus.disp_cz = 0; bus.disp_cmp = 0;
    repeat (3) step();
    vectors++;
    if (bus.iss_valid !== 1'b0 || bus.count !== 4'd0 || bus.iss_pc !== 16'd0 || bus.iss_opr1 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b cnt=%0d pc=%h expected 0 0 0000", bus.iss_valid, bus.count, bus.iss_pc);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (bus.disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b expected 1", bus.disp_ready);
    end
  endtask
  task automatic test_basic_add();
    drive_disp(16'h0010, 4'b0001, 16'd3, 1, 0, 16'd4, 1, 0, 5'd5, 16'd3, 16'd4, 1);
    vectors++;
    if (bus.count !== 4'd1 || bus.iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_after_dispatch got cnt=%0d v=%b expected 1 0", bus.count, bus.iss_valid);
    end
    step();
    vectors++;
    if (bus.iss_valid !== 1'b1 || bus.count !== 4'd0) begin
      miscompares++;
      $display("FAIL add_latency got v=%b cnt=%0d expected 1 0", bus.iss_valid, bus.count);
    end
    wait_drain("add");
  endtask
  task automatic test_cdb_wakeup();
    drive_disp(16'h0020, 4'b0010, 16'h0, 0, 5'd7, 16'hFFFF, 1, 0, 5'd6, 16'h00F0, 16'hFFFF, 1);
    step();
    broadcast(5'd7, 16'h00F0);
    vectors++;
    if (bus.iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wake_early_issue got %b expected 0", bus.iss_valid);
    end
    step();
    vectors++;
    if (bus.iss_valid !== 1'b1 || bus.iss_opr1 !== 16'h00F0) begin
      miscompares++;
      $display("FAIL wake_issue got v=%b opr1=%h expected 1 00f0", bus.iss_valid, bus.iss_opr1);
    end
    wait_drain("wake");
  endtask
  task automatic test_bypass();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd9; bus.cdb_data = 16'h1234;
    drive_disp(16'h0030, 4'b0001, 16'h0, 0, 5'd9, 16'h0001, 1, 0, 5'd8, 16'h1234, 16'h0001, 1);
    bus.cdb_valid = 1'b0;
    step();
    vectors++;
    if (bus.iss_valid !== 1'b1 || bus.iss_opr1 !== 16'h1234) begin
      miscompares++;
      $display("FAIL bypass_issue got v=%b opr1=%h expected 1 1234", bus.iss_valid, bus.iss_opr1);
    end
    wait_drain("bypass");
  endtask
  task automatic test_full();
    for (int i = 0; i < 8; i++)
      drive_disp(16'h0100 + 16'(i), 4'b0001, 16'h0, 0, 5'd3, 16'(i), 1, 0, 5'(i), 16'h0A0A, 16'(i), 1);
    vectors++;
    if (bus.count !== 4'd8 || bus.disp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state got cnt=%0d rdy=%b expected 8 0", bus.count, bus.disp_ready);
    end
    drive_disp(16'h0DEA, 4'b0001, 16'h1, 1, 0, 16'h1, 1, 0, 5'd31, 16'h1, 16'h1, 0);
    vectors++;
    if (bus.count !== 4'd8) begin
      miscompares++;
      $display("FAIL full_ignore got cnt=%0d expected 8", bus.count);
    end
    broadcast(5'd3, 16'h0A0A);
    vectors++;
    if (bus.disp_ready !== 1'b0 || bus.iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_wake got rdy=%b v=%b expected 0 0", bus.disp_ready, bus.iss_valid);
    end
    step();
    vectors++;
    if (bus.disp_ready !== 1'b1 || bus.count !== 4'd7 || bus.iss_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_first_issue got rdy=%b cnt=%0d v=%b expected 1 7 1", bus.disp_ready, bus.count, bus.iss_valid);
    end
    wait_drain("full");
  endtask
  task automatic test_flush();
    for (int i = 0; i < 4; i++)
      drive_disp(16'h0200 + 16'(i), 4'b0010, 16'h0, 0, 5'd20, 16'h5, 1, 0, 5'(i), 16'h0, 16'h0, 0);
    vectors++;
    if (bus.count !== 4'd4) begin
      miscompares++;
      $display("FAIL flush_pre got cnt=%0d expected 4", bus.count);
    end
    bus.flush = 1'b1;
    drive_disp(16'h0BAD, 4'b0001, 16'h7, 1, 0, 16'h7, 1, 0, 5'd9, 16'h7, 16'h7, 0);
    bus.flush = 1'b0;
    vectors++;
    if (bus.count !== 4'd0 || bus.iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_state got cnt=%0d v=%b expected 0 0", bus.count, bus.iss_valid);
    end
    broadcast(5'd20, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.iss_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_no_issue got %b expected 0", bus.iss_valid);
      end
      step();
    end
  endtask
  task automatic test_stale();
    drive_disp(16'h0300, 4'b0001, 16'h0, 0, 5'd12, 16'h0, 0, 5'd13, 5'd12, 16'hAAAA, 16'hCCCC, 1);
    step();
    broadcast(5'd12, 16'hAAAA);
    broadcast(5'd12, 16'hBBBB);
    broadcast(5'd13, 16'hCCCC);
    wait_drain("stale");
    drive_disp(16'h0301, 4'b0010, 16'h0, 0, 5'd14, 16'h0, 0, 5'd14, 5'd14, 16'h5555, 16'h5555, 1);
    broadcast(5'd14, 16'h5555);
    wait_drain("dual_wake");
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      drive_disp(16'h0400 + 16'(i), 4'b0001, 16'(i * 3), 1, 0, 16'(i + 9), 1, 0, 5'(i + 16),
                 16'(i * 3), 16'(i + 9), 1);
    vectors++;
    if (bus.iss_valid !== 1'b1 || bus.count !== 4'd1) begin
      miscompares++;
      $display("FAIL b2b_stream got v=%b cnt=%0d expected 1 1", bus.iss_valid, bus.count);
    end
    wait_drain("b2b");
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++)
      drive_disp(16'h0500 + 16'(i), 4'b0001, 16'h0, 0, 5'd11, 16'h2, 1, 0, 5'(i), 16'h1111, 16'h2, 1);
    broadcast(5'd11, 16'h1111);
    step();
    vectors++;
    if (bus.iss_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre got %b expected 1", bus.iss_valid);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.iss_valid !== 1'b0 || bus.count !== 4'd0 || bus.iss_pc !== 16'd0) begin
      miscompares++;
      $display("FAIL arst_clear got v=%b cnt=%0d pc=%h expected 0 0 0000", bus.iss_valid, bus.count, bus.iss_pc);
    end
    sb.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.iss_valid !== 1'b0 || bus.count !== 4'd0) begin
        miscompares++;
        $display("FAIL arst_after got v=%b cnt=%0d expected 0 0", bus.iss_valid, bus.count);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic_add();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_stale();
    test_back_to_back();
    test_async_reset();
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
